// File: rtl/adpll_loop_filter.sv
// adpll_loop_filter
//   Bang-bang ADPLL digital loop filter. Asynchronous PFD UP/DN requests are
//   synchronized and reduced to single-cycle edge pulses. A random-walk K
//   counter integrates them, and each overflow/underflow nudges the DCO
//   control word by one LSB, with saturation at both ends. An optional lock
//   detector reports lock after LOCK_CYCLES consecutive cycles without a
//   control-word update.
//
//   Optional feature macro: ADPLL_LF_LOCK_DETECT_EN
//     defined   -> lock FSM and quiet counter are built
//     undefined -> LOCK is tied to 0
//
// Ports
//   CLK      in   single clock; all state changes on its rising edge
//   RESET_B  in   synchronous active-low reset
//   UP       in   PFD up request (asynchronous to CLK)
//   DN       in   PFD down request (asynchronous to CLK)
//   CTRL     out  [CW_WIDTH-1:0] registered DCO control word
//   UPDATE   out  one-cycle pulse on every INC/DEC attempt
//   SAT      out  high while CTRL sits at 0 or all-ones
//   LOCK     out  registered lock indication
module adpll_loop_filter #(
  parameter int CW_WIDTH    = 6,
  parameter int K_WIDTH     = 4,
  parameter int CTRL_INIT   = 32,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                CLK,
  input  logic                RESET_B,
  input  logic                UP,
  input  logic                DN,
  output logic [CW_WIDTH-1:0] CTRL,
  output logic                UPDATE,
  output logic                SAT,
  output logic                LOCK
);

  localparam logic [K_WIDTH-1:0]  K_MID     = {1'b1, {(K_WIDTH-1){1'b0}}};
  localparam logic [K_WIDTH-1:0]  K_MAX     = {K_WIDTH{1'b1}};
  localparam logic [K_WIDTH-1:0]  K_MIN     = {K_WIDTH{1'b0}};
  localparam logic [CW_WIDTH-1:0] CTRL_MAX  = {CW_WIDTH{1'b1}};
  localparam logic [CW_WIDTH-1:0] CTRL_MIN  = {CW_WIDTH{1'b0}};
  localparam logic [CW_WIDTH-1:0] CTRL_RST  = CW_WIDTH'(CTRL_INIT);

  function automatic logic [CW_WIDTH-1:0] sat_inc(input logic [CW_WIDTH-1:0] v);
    return (v == CTRL_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [CW_WIDTH-1:0] sat_dec(input logic [CW_WIDTH-1:0] v);
    return (v == CTRL_MIN) ? v : v - 1'b1;
  endfunction

  logic               up_meta_p0, dn_meta_p0;
  logic               up_sync_p1, dn_sync_p1;
  logic               up_hist_p2, dn_hist_p2;
  logic               up_p, dn_p;
  logic [K_WIDTH-1:0] k_q, k_nxt;
  logic               inc_nxt, dec_nxt;
  logic               inc_p3, dec_p3;

  // ---- stage p0/p1: two-flop synchronizer, p2: history flop ----
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      up_meta_p0 <= 1'b0;
      dn_meta_p0 <= 1'b0;
      up_sync_p1 <= 1'b0;
      dn_sync_p1 <= 1'b0;
      up_hist_p2 <= 1'b0;
      dn_hist_p2 <= 1'b0;
    end else begin
      up_meta_p0 <= UP;
      dn_meta_p0 <= DN;
      up_sync_p1 <= up_meta_p0;
      dn_sync_p1 <= dn_meta_p0;
      up_hist_p2 <= up_sync_p1;
      dn_hist_p2 <= dn_sync_p1;
    end
  end

  assign up_p = up_sync_p1 & ~up_hist_p2;
  assign dn_p = dn_sync_p1 & ~dn_hist_p2;

  // ---- stage p3: random-walk K counter, registered INC/DEC ----
  // Simultaneous up and down edges cancel and leave K untouched.
  always_comb begin
    k_nxt   = k_q;
    inc_nxt = 1'b0;
    dec_nxt = 1'b0;
    if (up_p && !dn_p) begin
      if (k_q == K_MAX) begin
        k_nxt   = K_MID;
        inc_nxt = 1'b1;
      end else begin
        k_nxt = k_q + 1'b1;
      end
    end else if (dn_p && !up_p) begin
      if (k_q == K_MIN) begin
        k_nxt   = K_MID;
        dec_nxt = 1'b1;
      end else begin
        k_nxt = k_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      k_q    <= K_MID;
      inc_p3 <= 1'b0;
      dec_p3 <= 1'b0;
      UPDATE <= 1'b0;
    end else begin
      k_q    <= k_nxt;
      inc_p3 <= inc_nxt;
      dec_p3 <= dec_nxt;
      UPDATE <= inc_nxt | dec_nxt;
    end
  end

  // ---- stage p4: saturating control word ----
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      CTRL <= CTRL_RST;
    end else if (inc_p3) begin
      CTRL <= sat_inc(CTRL);
    end else if (dec_p3) begin
      CTRL <= sat_dec(CTRL);
    end
  end

  assign SAT = (CTRL == CTRL_MIN) || (CTRL == CTRL_MAX);

`ifdef ADPLL_LF_LOCK_DETECT_EN
  localparam int            QW        = $clog2(LOCK_CYCLES + 1);
  localparam logic [QW-1:0] QUIET_MAX = QW'(LOCK_CYCLES);

  typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} lock_state_t;

  lock_state_t   state_q, state_nxt;
  logic [QW-1:0] quiet_q;

  // ---- lock detect: quiet counter, state register and LOCK flag ----
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      state_q <= ACQUIRE;
      quiet_q <= '0;
      LOCK    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      LOCK    <= (state_nxt == LOCKED);
      if (UPDATE) begin
        quiet_q <= '0;
      end else if (quiet_q != QUIET_MAX) begin
        quiet_q <= quiet_q + 1'b1;
      end
    end
  end

  // An update in the very cycle the count is reached wins over locking.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ACQUIRE: if (quiet_q == QUIET_MAX && !UPDATE) state_nxt = LOCKED;
      LOCKED:  if (UPDATE) state_nxt = ACQUIRE;
      default: state_nxt = ACQUIRE;
    endcase
  end
`else
  assign LOCK = 1'b0;
`endif

endmodule

// File: tb/tb_adpll_loop_filter.sv
module tb_adpll_loop_filter;

`ifdef ADPLL_LF_LOCK_DETECT_EN
  localparam logic LD = 1'b1;
`else
  localparam logic LD = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_B = 1'b0;
  logic       UP = 1'b0;
  logic       DN = 1'b0;
  logic [5:0] CTRL;
  logic       UPDATE, SAT, LOCK;

  int n_checks = 0;
  int n_fail = 0;
  int upd_cnt = 0;

  adpll_loop_filter dut (
    .CLK(CLK), .RESET_B(RESET_B), .UP(UP), .DN(DN),
    .CTRL(CTRL), .UPDATE(UPDATE), .SAT(SAT), .LOCK(LOCK)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (UPDATE === 1'b1) upd_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic u, input logic d);
    @(negedge CLK);
    UP = u; DN = d;
    repeat (4) @(negedge CLK);
    UP = 1'b0; DN = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic pulses(input int n, input logic u, input logic d);
    for (int i = 0; i < n; i++) pulse(u, d);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_B = 1'b0; UP = 1'b0; DN = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_B = 1'b1;
  endtask

  task automatic test_reset();
    UP = 1'b1; DN = 1'b0; RESET_B = 1'b0;
    repeat (3) @(negedge CLK);
    UP = 1'b0;
    n_checks++; if (CTRL !== 6'd32) begin n_fail++; $display("FAIL reset_ctrl: got %0d expected 32", CTRL); end
    n_checks++; if (LOCK !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b expected 0", LOCK); end
    n_checks++; if (SAT !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", SAT); end
    n_checks++; if (UPDATE !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b expected 0", UPDATE); end
    RESET_B = 1'b1;
  endtask

  task automatic test_update_latency();
    int snap;
    do_reset();
    snap = upd_cnt;
    pulses(7, 1'b1, 1'b0);
    n_checks++; if (upd_cnt - snap !== 0) begin n_fail++; $display("FAIL seven_up_updates: got %0d expected 0", upd_cnt - snap); end
    n_checks++; if (CTRL !== 6'd32) begin n_fail++; $display("FAIL seven_up_ctrl: got %0d expected 32", CTRL); end
    @(negedge CLK);
    UP = 1'b1;
    @(negedge CLK);
    n_checks++; if (UPDATE !== 1'b0) begin n_fail++; $display("FAIL lat_n_update: got %b expected 0", UPDATE); end
    @(negedge CLK);
    n_checks++; if (UPDATE !== 1'b0) begin n_fail++; $display("FAIL lat_n1_update: got %b expected 0", UPDATE); end
    @(negedge CLK);
    n_checks++; if (UPDATE !== 1'b1) begin n_fail++; $display("FAIL lat_n2_update: got %b expected 1", UPDATE); end
    n_checks++; if (CTRL !== 6'd32) begin n_fail++; $display("FAIL lat_n2_ctrl: got %0d expected 32", CTRL); end
    @(negedge CLK);
    n_checks++; if (CTRL !== 6'd33) begin n_fail++; $display("FAIL lat_n3_ctrl: got %0d expected 33", CTRL); end
    n_checks++; if (UPDATE !== 1'b0) begin n_fail++; $display("FAIL lat_n3_update: got %b expected 0", UPDATE); end
    UP = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_cancel();
    int snap;
    do_reset();
    snap = upd_cnt;
    pulses(20, 1'b1, 1'b1);
    n_checks++; if (CTRL !== 6'd32) begin n_fail++; $display("FAIL cancel_ctrl: got %0d expected 32", CTRL); end
    n_checks++; if (upd_cnt - snap !== 0) begin n_fail++; $display("FAIL cancel_updates: got %0d expected 0", upd_cnt - snap); end
    pulses(7, 1'b1, 1'b0);
    n_checks++; if (upd_cnt - snap !== 0) begin n_fail++; $display("FAIL cancel_k_mid7: got %0d expected 0", upd_cnt - snap); end
    pulse(1'b1, 1'b0);
    n_checks++; if (upd_cnt - snap !== 1) begin n_fail++; $display("FAIL cancel_k_mid8: got %0d expected 1", upd_cnt - snap); end
    n_checks++; if (CTRL !== 6'd33) begin n_fail++; $display("FAIL cancel_ctrl33: got %0d expected 33", CTRL); end
  endtask

  task automatic test_updown_walk();
    int snap;
    do_reset();
    snap = upd_cnt;
    pulses(5, 1'b1, 1'b0);
    pulses(5, 1'b0, 1'b1);
    pulses(8, 1'b0, 1'b1);
    n_checks++; if (upd_cnt - snap !== 0) begin n_fail++; $display("FAIL walk_no_update: got %0d expected 0", upd_cnt - snap); end
    pulse(1'b0, 1'b1);
    n_checks++; if (upd_cnt - snap !== 1) begin n_fail++; $display("FAIL walk_underflow: got %0d expected 1", upd_cnt - snap); end
    n_checks++; if (CTRL !== 6'd31) begin n_fail++; $display("FAIL walk_ctrl: got %0d expected 31", CTRL); end
  endtask

  task automatic test_saturation();
    int snap;
    do_reset();
    pulses(247, 1'b1, 1'b0);
    n_checks++; if (CTRL !== 6'd62) begin n_fail++; $display("FAIL sat_up247_ctrl: got %0d expected 62", CTRL); end
    n_checks++; if (SAT !== 1'b0) begin n_fail++; $display("FAIL sat_up247_sat: got %b expected 0", SAT); end
    pulse(1'b1, 1'b0);
    n_checks++; if (CTRL !== 6'd63) begin n_fail++; $display("FAIL sat_up248_ctrl: got %0d expected 63", CTRL); end
    n_checks++; if (SAT !== 1'b1) begin n_fail++; $display("FAIL sat_up248_sat: got %b expected 1", SAT); end
    snap = upd_cnt;
    pulses(8, 1'b1, 1'b0);
    n_checks++; if (upd_cnt - snap !== 1) begin n_fail++; $display("FAIL sat_hi_update: got %0d expected 1", upd_cnt - snap); end
    n_checks++; if (CTRL !== 6'd63) begin n_fail++; $display("FAIL sat_hi_hold: got %0d expected 63", CTRL); end

    do_reset();
    snap = upd_cnt;
    pulses(287, 1'b0, 1'b1);
    n_checks++; if (CTRL !== 6'd1) begin n_fail++; $display("FAIL sat_dn287_ctrl: got %0d expected 1", CTRL); end
    n_checks++; if (SAT !== 1'b0) begin n_fail++; $display("FAIL sat_dn287_sat: got %b expected 0", SAT); end
    pulse(1'b0, 1'b1);
    n_checks++; if (CTRL !== 6'd0) begin n_fail++; $display("FAIL sat_dn288_ctrl: got %0d expected 0", CTRL); end
    n_checks++; if (SAT !== 1'b1) begin n_fail++; $display("FAIL sat_dn288_sat: got %b expected 1", SAT); end
    n_checks++; if (upd_cnt - snap !== 32) begin n_fail++; $display("FAIL sat_dn_updates: got %0d expected 32", upd_cnt - snap); end
    snap = upd_cnt;
    pulses(9, 1'b0, 1'b1);
    n_checks++; if (upd_cnt - snap !== 1) begin n_fail++; $display("FAIL sat_lo_update: got %0d expected 1", upd_cnt - snap); end
    n_checks++; if (CTRL !== 6'd0) begin n_fail++; $display("FAIL sat_lo_hold: got %0d expected 0", CTRL); end
  endtask

  task automatic test_lock();
    logic found;
    do_reset();
    repeat (64) @(negedge CLK);
    n_checks++; if (LOCK !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b expected 0", LOCK); end
    @(negedge CLK);
    n_checks++; if (LOCK !== LD) begin n_fail++; $display("FAIL lock_rise: got %b expected %b", LOCK, LD); end
    pulses(8, 1'b0, 1'b1);
    n_checks++; if (LOCK !== LD) begin n_fail++; $display("FAIL lock_hold: got %b expected %b", LOCK, LD); end
    @(negedge CLK);
    DN = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge CLK);
      if (UPDATE === 1'b1) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL lock_update_seen: got %b expected 1", found); end
    n_checks++; if (LOCK !== LD) begin n_fail++; $display("FAIL lock_at_update: got %b expected %b", LOCK, LD); end
    @(negedge CLK);
    n_checks++; if (LOCK !== 1'b0) begin n_fail++; $display("FAIL lock_fall: got %b expected 0", LOCK); end
    n_checks++; if (CTRL !== 6'd31) begin n_fail++; $display("FAIL lock_ctrl: got %0d expected 31", CTRL); end
    repeat (2) @(negedge CLK);
    DN = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int snap;
    do_reset();
    pulses(70, 1'b1, 1'b0);
    n_checks++; if (CTRL !== 6'd40) begin n_fail++; $display("FAIL mid_pre_ctrl: got %0d expected 40", CTRL); end
    @(negedge CLK);
    RESET_B = 1'b0;
    @(negedge CLK);
    RESET_B = 1'b1;
    n_checks++; if (CTRL !== 6'd32) begin n_fail++; $display("FAIL mid_ctrl: got %0d expected 32", CTRL); end
    n_checks++; if (LOCK !== 1'b0) begin n_fail++; $display("FAIL mid_lock: got %b expected 0", LOCK); end
    snap = upd_cnt;
    pulses(7, 1'b1, 1'b0);
    n_checks++; if (upd_cnt - snap !== 0) begin n_fail++; $display("FAIL mid_k7: got %0d expected 0", upd_cnt - snap); end
    pulse(1'b1, 1'b0);
    n_checks++; if (upd_cnt - snap !== 1) begin n_fail++; $display("FAIL mid_k8: got %0d expected 1", upd_cnt - snap); end

    // UP held high across reset release yields exactly one edge (K 8 -> 9)
    @(negedge CLK);
    RESET_B = 1'b0; UP = 1'b1;
    repeat (2) @(negedge CLK);
    RESET_B = 1'b1;
    repeat (4) @(negedge CLK);
    UP = 1'b0;
    repeat (4) @(negedge CLK);
    n_checks++; if (CTRL !== 6'd32) begin n_fail++; $display("FAIL held_ctrl: got %0d expected 32", CTRL); end
    snap = upd_cnt;
    pulses(6, 1'b1, 1'b0);
    n_checks++; if (upd_cnt - snap !== 0) begin n_fail++; $display("FAIL held_k6: got %0d expected 0", upd_cnt - snap); end
    pulse(1'b1, 1'b0);
    n_checks++; if (upd_cnt - snap !== 1) begin n_fail++; $display("FAIL held_k7: got %0d expected 1", upd_cnt - snap); end
    n_checks++; if (CTRL !== 6'd33) begin n_fail++; $display("FAIL held_ctrl33: got %0d expected 33", CTRL); end
  endtask

  initial begin
    test_reset();
    test_update_latency();
    test_cancel();
    test_updown_walk();
    test_saturation();
    test_lock();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
